// File: rtl/bp_commit_pc_sampler_pkg.sv
// Shared types for the commit PC sampler: the sample record macro and FSM states.
`ifndef BP_PC_SAMPLE_SVH
`define BP_PC_SAMPLE_SVH

// One captured sample: retired PC, cycle stamp of the fire cycle, sequence number.
`define BP_DECLARE_PC_SAMPLE_S(vaddr_width_mp, cycle_width_mp, seq_width_mp) \
    typedef struct packed {                                                   \
        logic [vaddr_width_mp-1:0] pc;                                        \
        logic [cycle_width_mp-1:0] cycle;                                     \
        logic [seq_width_mp-1:0]   seq;                                       \
    } bp_pc_sample_s

`define BP_PC_SAMPLE_WIDTH(vaddr_width_mp, cycle_width_mp, seq_width_mp) \
    ((vaddr_width_mp) + (cycle_width_mp) + (seq_width_mp))

`endif

package bp_commit_pc_sampler_pkg;

    // Sampler is either parked (reloading the countdown) or watching retires.
    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_run  = 1'b1
    } bp_sampler_state_e;

endpackage

// File: rtl/bp_pc_sample_fifo.sv
// 1r1w circular buffer of PC samples. Full/empty come from pointers carrying a
// wrap bit; a write is accepted when full if the head leaves in the same cycle.
module bp_pc_sample_fifo
    import bp_commit_pc_sampler_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int cycle_width_p = 32,
    parameter int seq_width_p   = 16,
    parameter int els_p         = 4,
    localparam int sample_width_lp = `BP_PC_SAMPLE_WIDTH(vaddr_width_p, cycle_width_p, seq_width_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_li,
    input  logic                       v_i,
    input  logic [sample_width_lp-1:0] data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [sample_width_lp-1:0] data_o,
    input  logic                       yumi_i
);
    `BP_DECLARE_PC_SAMPLE_S(vaddr_width_p, cycle_width_p, seq_width_p);

    localparam int ptr_width_lp = $clog2(els_p);

    bp_pc_sample_s           mem_r [els_p];
    logic [ptr_width_lp:0]   wptr_r, rptr_r;
    logic                    empty, full, enq, deq;

    assign empty   = (wptr_r == rptr_r);
    assign full    = (wptr_r[ptr_width_lp] != rptr_r[ptr_width_lp])
                  && (wptr_r[ptr_width_lp-1:0] == rptr_r[ptr_width_lp-1:0]);
    assign deq     = yumi_i & ~empty;
    // A full buffer can still take a write when the head is popped this cycle;
    // the freed slot is the one being written, and the read below sees the old value.
    assign ready_o = ~full | deq;
    assign enq     = v_i & ready_o;
    assign v_o     = ~empty;
    assign data_o  = mem_r[rptr_r[ptr_width_lp-1:0]];

    // Storage: no reset needed, validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r[ptr_width_lp-1:0]] <= bp_pc_sample_s'(data_i);
    end

    // Pointer update; reset drops every stored sample.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (enq) wptr_r <= wptr_r + (ptr_width_lp+1)'(1);
            if (deq) rptr_r <= rptr_r + (ptr_width_lp+1)'(1);
        end
    end

endmodule

// File: rtl/bp_commit_pc_sampler.sv
// Watches the retire stream, captures every Nth retired PC with a cycle stamp and
// sequence number, and queues the samples for a valid/yumi consumer.
module bp_commit_pc_sampler
    import bp_commit_pc_sampler_pkg::*;
#(
    parameter int vaddr_width_p  = 39,
    parameter int fifo_els_p     = 4,
    parameter int period_width_p = 16,
    parameter int cycle_width_p  = 32,
    parameter int seq_width_p    = 16,
    parameter int drop_width_p   = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_li,
    input  logic                      en_i,
    input  logic [period_width_p-1:0] period_i,
    input  logic                      commit_v_i,
    input  logic [vaddr_width_p-1:0]  commit_pc_i,
    output logic                      sample_v_o,
    output logic [vaddr_width_p-1:0]  sample_pc_o,
    output logic [cycle_width_p-1:0]  sample_cycle_o,
    output logic [seq_width_p-1:0]    sample_seq_o,
    input  logic                      sample_yumi_i,
    output logic [drop_width_p-1:0]   drop_count_o
);
    `BP_DECLARE_PC_SAMPLE_S(vaddr_width_p, cycle_width_p, seq_width_p);

    localparam int sample_width_lp = `BP_PC_SAMPLE_WIDTH(vaddr_width_p, cycle_width_p, seq_width_p);
    localparam logic [period_width_p-1:0] one_lp = period_width_p'(1);

    bp_sampler_state_e           state_r, state_n;
    logic [period_width_p-1:0]   countdown_r, countdown_n, period_eff;
    logic [cycle_width_p-1:0]    cycle_r;
    logic [seq_width_p-1:0]      seq_r;
    logic [drop_width_p-1:0]     drop_r;
    logic                        fire, fifo_ready, enq_li, drop_li, yumi_li;
    bp_pc_sample_s               fire_sample, head_sample;
    logic [sample_width_lp-1:0]  head_data;

    // A zero period would never fire; treat it as "every retire".
    assign period_eff = (period_i == '0) ? one_lp : period_i;

    // Next-state and countdown: reload while parked, count retires while running.
    always_comb begin
        state_n     = state_r;
        countdown_n = countdown_r;
        fire        = 1'b0;
        case (state_r)
            e_idle: begin
                countdown_n = period_eff;
                if (en_i) state_n = e_run;
            end
            e_run: begin
                if (!en_i) state_n = e_idle;
                if (commit_v_i) begin
                    if (countdown_r == one_lp) begin
                        fire        = 1'b1;
                        countdown_n = period_eff;
                    end else begin
                        countdown_n = countdown_r - one_lp;
                    end
                end
            end
            default: state_n = e_idle;
        endcase
    end

    // FSM state and countdown registers.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            state_r     <= e_idle;
            countdown_r <= one_lp;
        end else begin
            state_r     <= state_n;
            countdown_r <= countdown_n;
        end
    end

    // Only pop when there is a head; an illegal yumi is ignored.
    assign yumi_li = sample_yumi_i & sample_v_o;
    assign enq_li  = fire & fifo_ready;
    assign drop_li = fire & ~fifo_ready;

    assign fire_sample.pc    = commit_pc_i;
    assign fire_sample.cycle = cycle_r;
    assign fire_sample.seq   = seq_r;

    // Free-running timestamp, sequence (bumped on every fire, kept or dropped)
    // and saturating drop counter.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            cycle_r <= '0;
            seq_r   <= '0;
            drop_r  <= '0;
        end else begin
            cycle_r <= cycle_r + cycle_width_p'(1);
            if (fire) seq_r <= seq_r + seq_width_p'(1);
            if (drop_li && (drop_r != '1)) drop_r <= drop_r + drop_width_p'(1);
        end
    end

    bp_pc_sample_fifo #(
        .vaddr_width_p (vaddr_width_p),
        .cycle_width_p (cycle_width_p),
        .seq_width_p   (seq_width_p),
        .els_p         (fifo_els_p)
    ) fifo (
        .clk_i    (clk_i),
        .reset_li (reset_li),
        .v_i      (fire),
        .data_i   (fire_sample),
        .ready_o  (fifo_ready),
        .v_o      (sample_v_o),
        .data_o   (head_data),
        .yumi_i   (yumi_li)
    );

    assign head_sample    = bp_pc_sample_s'(head_data);
    assign sample_pc_o    = head_sample.pc;
    assign sample_cycle_o = head_sample.cycle;
    assign sample_seq_o   = head_sample.seq;
    assign drop_count_o   = drop_r;

    // Consumer must only dequeue a valid head.
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_li)
                                       sample_yumi_i |-> sample_v_o)
        else $error("sample_yumi_i asserted with empty sample FIFO");

    // enq_li is the accepted-fire qualifier kept for readability of the datapath.
    logic unused_enq;
    assign unused_enq = enq_li;

endmodule

// File: tb/tb_bp_commit_pc_sampler.sv
// Directed bench for bp_commit_pc_sampler: one task per scenario, inline checks.
module tb_bp_commit_pc_sampler;

    logic        clk_i, reset_li, en_i, commit_v_i, sample_yumi_i;
    logic [15:0] period_i;
    logic [38:0] commit_pc_i, sample_pc_o, sat_pc;
    logic        sample_v_o, sat_v;
    logic [31:0] sample_cycle_o, sat_cycle;
    logic [15:0] sample_seq_o, sat_seq;
    logic [15:0] drop_count_o;
    logic [3:0]  sat_drop;

    int tests = 0;
    int fails = 0;

    logic [38:0] obs_pc[$];
    logic [31:0] obs_cyc[$];
    logic [15:0] obs_seq[$];

    bp_commit_pc_sampler dut (
        .clk_i(clk_i), .reset_li(reset_li), .en_i(en_i), .period_i(period_i),
        .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i),
        .sample_v_o(sample_v_o), .sample_pc_o(sample_pc_o),
        .sample_cycle_o(sample_cycle_o), .sample_seq_o(sample_seq_o),
        .sample_yumi_i(sample_yumi_i), .drop_count_o(drop_count_o)
    );

    // Narrow drop counter copy so saturation is reachable in a short run.
    bp_commit_pc_sampler #(.drop_width_p(4)) dut_sat (
        .clk_i(clk_i), .reset_li(reset_li), .en_i(en_i), .period_i(period_i),
        .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i),
        .sample_v_o(sat_v), .sample_pc_o(sat_pc),
        .sample_cycle_o(sat_cycle), .sample_seq_o(sat_seq),
        .sample_yumi_i(sample_yumi_i), .drop_count_o(sat_drop)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One clock of stimulus; pops (and records) the head when asked and valid.
    task automatic step(input logic c, input logic [38:0] pc, input logic y);
        commit_v_i    = c;
        commit_pc_i   = pc;
        sample_yumi_i = y && sample_v_o;
        if (sample_yumi_i) begin
            obs_pc.push_back(sample_pc_o);
            obs_cyc.push_back(sample_cycle_o);
            obs_seq.push_back(sample_seq_o);
        end
        @(posedge clk_i); #1;
        commit_v_i    = 1'b0;
        sample_yumi_i = 1'b0;
    endtask

    // Reset and release one tick after an edge, so the first cycle sees cycle=0.
    task automatic do_reset();
        en_i = 0; commit_v_i = 0; commit_pc_i = '0; sample_yumi_i = 0; period_i = 16'd1;
        reset_li = 0;
        obs_pc.delete(); obs_cyc.delete(); obs_seq.delete();
        repeat (2) @(posedge clk_i);
        #1 reset_li = 1;
    endtask

    task automatic test_reset();
        en_i = 0; commit_v_i = 0; commit_pc_i = '0; sample_yumi_i = 0; period_i = 16'd1;
        reset_li = 0;
        repeat (2) @(posedge clk_i);
        #1;
        tests++; if (sample_v_o !== 1'b0) begin fails++; $display("FAIL reset_v got=%b exp=0", sample_v_o); end
        tests++; if (drop_count_o !== 16'd0) begin fails++; $display("FAIL reset_drops got=%0d exp=0", drop_count_o); end
        reset_li = 1;
        // Retires while disabled must never sample.
        for (int i = 0; i < 3; i++) step(1'b1, 39'h100 + 39'(4*i), 1'b0);
        tests++; if (sample_v_o !== 1'b0) begin fails++; $display("FAIL idle_no_sample got=%b exp=0", sample_v_o); end
    endtask

    task automatic test_every_pc();
        do_reset();
        en_i = 1; period_i = 16'd1;
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 39'h80000000 + 39'(4*i), 1'b1);
        step(1'b0, '0, 1'b1);
        tests++; if (obs_pc.size() !== 8) begin fails++; $display("FAIL p1_count got=%0d exp=8", obs_pc.size()); end
        for (int i = 0; i < 8 && i < obs_pc.size(); i++) begin
            tests++;
            if ({obs_pc[i], obs_seq[i], obs_cyc[i]} !== {39'h80000000 + 39'(4*i), 16'(i), 32'(i+1)}) begin
                fails++;
                $display("FAIL p1_sample%0d got pc=%h seq=%0d cyc=%0d exp pc=%h seq=%0d cyc=%0d", i,
                         obs_pc[i], obs_seq[i], obs_cyc[i], 39'h80000000 + 39'(4*i), i, i+1);
            end
        end
        tests++; if ({sample_v_o, drop_count_o} !== {1'b0, 16'd0}) begin fails++; $display("FAIL p1_end got v=%b drops=%0d exp v=0 drops=0", sample_v_o, drop_count_o); end
    endtask

    task automatic test_period3();
        logic [38:0] exp_pc [3];
        logic [31:0] exp_cyc [3];
        exp_pc[0] = 39'h1008; exp_pc[1] = 39'h1014; exp_pc[2] = 39'h1020;
        exp_cyc[0] = 32'd3;   exp_cyc[1] = 32'd6;   exp_cyc[2] = 32'd9;
        do_reset();
        en_i = 1; period_i = 16'd3;
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 39'h1000 + 39'(4*i), 1'b1);
        step(1'b0, '0, 1'b1);
        tests++; if (obs_pc.size() !== 3) begin fails++; $display("FAIL p3_count got=%0d exp=3", obs_pc.size()); end
        for (int i = 0; i < 3 && i < obs_pc.size(); i++) begin
            tests++;
            if ({obs_pc[i], obs_seq[i], obs_cyc[i]} !== {exp_pc[i], 16'(i), exp_cyc[i]}) begin
                fails++;
                $display("FAIL p3_sample%0d got pc=%h seq=%0d cyc=%0d exp pc=%h seq=%0d cyc=%0d", i,
                         obs_pc[i], obs_seq[i], obs_cyc[i], exp_pc[i], i, exp_cyc[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        en_i = 1; period_i = 16'd1;
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 39'h2000 + 39'(4*i), 1'b0);
        tests++;
        if ({sample_v_o, drop_count_o, sample_seq_o} !== {1'b1, 16'd2, 16'd0}) begin
            fails++;
            $display("FAIL ovf_full got v=%b drops=%0d seq=%0d exp v=1 drops=2 seq=0", sample_v_o, drop_count_o, sample_seq_o);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        tests++; if (obs_seq.size() !== 4) begin fails++; $display("FAIL ovf_drain_count got=%0d exp=4", obs_seq.size()); end
        for (int i = 0; i < 4 && i < obs_seq.size(); i++) begin
            tests++;
            if ({obs_pc[i], obs_seq[i]} !== {39'h2000 + 39'(4*i), 16'(i)}) begin
                fails++;
                $display("FAIL ovf_drain%0d got pc=%h seq=%0d exp pc=%h seq=%0d", i, obs_pc[i], obs_seq[i], 39'h2000 + 39'(4*i), i);
            end
        end
        tests++; if (sample_v_o !== 1'b0) begin fails++; $display("FAIL ovf_empty got=%b exp=0", sample_v_o); end
    endtask

    task automatic test_full_enq_deq();
        do_reset();
        en_i = 1; period_i = 16'd1;
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 39'h3000 + 39'(4*i), 1'b0);
        step(1'b1, 39'h3010, 1'b1);
        tests++; if ({sample_v_o, drop_count_o} !== {1'b1, 16'd0}) begin fails++; $display("FAIL fed_accept got v=%b drops=%0d exp v=1 drops=0", sample_v_o, drop_count_o); end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        tests++; if (sample_v_o !== 1'b0) begin fails++; $display("FAIL fed_occupancy got v=%b exp=0 after 4 pops", sample_v_o); end
        tests++; if (obs_seq.size() !== 5) begin fails++; $display("FAIL fed_count got=%0d exp=5", obs_seq.size()); end
        for (int i = 0; i < 5 && i < obs_seq.size(); i++) begin
            tests++;
            if ({obs_pc[i], obs_seq[i]} !== {39'h3000 + 39'(4*i), 16'(i)}) begin
                fails++;
                $display("FAIL fed_order%0d got pc=%h seq=%0d exp pc=%h seq=%0d", i, obs_pc[i], obs_seq[i], 39'h3000 + 39'(4*i), i);
            end
        end
    endtask

    task automatic test_reenable();
        do_reset();
        en_i = 1; period_i = 16'd5;
        step(1'b0, '0, 1'b0);
        step(1'b1, 39'h4000, 1'b0);
        step(1'b1, 39'h4004, 1'b0);
        en_i = 0;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        en_i = 1;
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 39'h4100 + 39'(4*i), 1'b0);
        tests++; if (sample_v_o !== 1'b0) begin fails++; $display("FAIL reen_early got v=%b exp=0 after 4 retires", sample_v_o); end
        step(1'b1, 39'h4110, 1'b0);
        tests++;
        if ({sample_v_o, sample_pc_o, sample_seq_o} !== {1'b1, 39'h4110, 16'd0}) begin
            fails++;
            $display("FAIL reen_fire got v=%b pc=%h seq=%0d exp v=1 pc=4110 seq=0", sample_v_o, sample_pc_o, sample_seq_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en_i = 1; period_i = 16'd1;
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 39'h5000 + 39'(4*i), 1'b0);
        en_i = 0;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        tests++; if ({sample_v_o, drop_count_o} !== {1'b1, 16'd7}) begin fails++; $display("FAIL rmid_pre got v=%b drops=%0d exp v=1 drops=7", sample_v_o, drop_count_o); end
        #2 reset_li = 0;
        #1;
        tests++; if ({sample_v_o, drop_count_o} !== {1'b0, 16'd0}) begin fails++; $display("FAIL rmid_async got v=%b drops=%0d exp v=0 drops=0", sample_v_o, drop_count_o); end
        @(posedge clk_i); #1 reset_li = 1;
        en_i = 1; period_i = 16'd1;
        step(1'b0, '0, 1'b0);
        step(1'b1, 39'h6000, 1'b0);
        tests++;
        if ({sample_v_o, sample_pc_o, sample_seq_o, sample_cycle_o} !== {1'b1, 39'h6000, 16'd0, 32'd1}) begin
            fails++;
            $display("FAIL rmid_restart got v=%b pc=%h seq=%0d cyc=%0d exp v=1 pc=6000 seq=0 cyc=1",
                     sample_v_o, sample_pc_o, sample_seq_o, sample_cycle_o);
        end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        en_i = 1; period_i = 16'd0;  // zero behaves as one
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 19; i++) step(1'b1, 39'h7000 + 39'(4*i), 1'b0);
        tests++; if ({drop_count_o, sat_drop} !== {16'd15, 4'hF}) begin fails++; $display("FAIL sat_reach got drops=%0d sat=%h exp drops=15 sat=f", drop_count_o, sat_drop); end
        for (int i = 0; i < 5; i++) step(1'b1, 39'h7100 + 39'(4*i), 1'b0);
        tests++; if ({drop_count_o, sat_drop} !== {16'd20, 4'hF}) begin fails++; $display("FAIL sat_hold got drops=%0d sat=%h exp drops=20 sat=f", drop_count_o, sat_drop); end
        tests++; if (sample_seq_o !== 16'd0) begin fails++; $display("FAIL sat_head got seq=%0d exp=0", sample_seq_o); end
    endtask

    initial begin
        test_reset();
        test_every_pc();
        test_period3();
        test_overflow();
        test_full_enq_deq();
        test_reenable();
        test_reset_mid();
        test_drop_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
